ctrl_mc: RTL and testbench

//  Parametrised multi-cycle successor of the core control unit. Decodes opcode/func3/b into the

---
 rtl/ctrl_mc.sv | 198 +++++++++++++++++++
 tb/tb_ctrl_mc.sv | 127 ++++++++++++
 2 files changed

// File: rtl/ctrl_mc.sv
// Multi-cycle control unit: decodes opcode/func3/b into datapath selects through a
// FLUSH/EXEC/MEM_WAIT/WB state machine with a timed req/ack data-memory handshake.
module ctrl_mc #(
  parameter int FLUSH_SLOTS = 1,
  parameter int RST_NOPS    = 1,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] opcode,
  input  logic [2:0] func3,
  input  logic       b,
  input  logic [1:0] addr_lo,
  input  logic       hold,
  input  logic       mem_ack,
  output logic       mem_req,
  output logic       we,
  output logic [3:0] mem_be,
  output logic       reg_wr,
  output logic [1:0] pc_sel,
  output logic       mem_sel,
  output logic [1:0] inst_sel,
  output logic       bus_err
);
  localparam logic [4:0] OPC_LOAD = 5'b00000, OPC_STORE = 5'b01000, OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_JAL = 5'b11011, OPC_JALR = 5'b11001, OPC_OP = 5'b01100;
  localparam logic [4:0] OPC_OP_IMM = 5'b00100, OPC_LUI = 5'b01101;
  localparam logic [2:0] F3_SB = 3'b000, F3_SH = 3'b001, F3_SBU = 3'b100, F3_SHU = 3'b101;
  localparam logic [1:0] PC_P4 = 2'd0, PC_ALU = 2'd1, PC_OLD = 2'd2;
  localparam logic       MEM_PC = 1'b0, MEM_ALU = 1'b1;
  localparam logic [1:0] INST_MEM = 2'd0, INST_OLD = 2'd1, INST_NOP = 2'd2;

  localparam int FC_MAX = (FLUSH_SLOTS > RST_NOPS) ? FLUSH_SLOTS : RST_NOPS;
  localparam int FC_W   = $clog2(FC_MAX + 1);
  localparam int TO_W   = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam bit TO_EN  = (MEM_TIMEOUT != 0);
  localparam logic [FC_W-1:0] FC_SLOTS = FC_W'(FLUSH_SLOTS);
  localparam logic [FC_W-1:0] FC_RST   = FC_W'(RST_NOPS);
  localparam logic [TO_W-1:0] TO_MAX   = TO_W'(MEM_TIMEOUT);
  localparam logic [TO_W-1:0] TO_SAT   = '1;

  typedef enum logic [1:0] {S_FLUSH = 2'd0, S_EXEC = 2'd1, S_MEM_WAIT = 2'd2, S_WB = 2'd3} state_t;

  state_t          state_r, next_state_s;
  logic [FC_W-1:0] flush_cnt_r, flush_cnt_nxt_s;
  logic [TO_W-1:0] to_cnt_r, to_cnt_nxt_s;
  logic            post_rst_r;
  logic            is_load_s, is_store_s, is_mem_s, redirect_s, writes_rd_s, timeout_s;

  function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] lo);
    case (f3)
      F3_SB, F3_SBU: byte_en = 4'b0001 << lo;
      F3_SH, F3_SHU: byte_en = 4'b0011 << {lo[1], 1'b0};
      default:       byte_en = 4'b1111;
    endcase
  endfunction

  assign is_load_s  = (opcode == OPC_LOAD);
  assign is_store_s = (opcode == OPC_STORE);
  assign is_mem_s   = is_load_s || is_store_s;
  assign redirect_s = (opcode == OPC_JAL) || (opcode == OPC_JALR) || ((opcode == OPC_BRANCH) && b);
  assign timeout_s  = TO_EN && (to_cnt_r == TO_MAX) && !mem_ack;

  // Opcodes that write the register file directly from EXEC
  always_comb begin
    case (opcode)
      OPC_JAL, OPC_JALR, OPC_OP, OPC_OP_IMM, OPC_LUI: writes_rd_s = 1'b1;
      default:                                        writes_rd_s = 1'b0;
    endcase
  end

  // State and counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= S_FLUSH;
      flush_cnt_r <= FC_RST;
      to_cnt_r    <= '0;
      post_rst_r  <= 1'b1;
    end else begin
      state_r     <= next_state_s;
      flush_cnt_r <= flush_cnt_nxt_s;
      to_cnt_r    <= to_cnt_nxt_s;
      post_rst_r  <= 1'b0;
    end
  end

  // Next state; hold freezes everything
  always_comb begin
    next_state_s    = state_r;
    flush_cnt_nxt_s = flush_cnt_r;
    to_cnt_nxt_s    = to_cnt_r;
    if (hold) begin
      next_state_s = state_r;
    end else begin
      case (state_r)
        S_FLUSH: begin
          if (flush_cnt_r <= FC_W'(1)) begin
            next_state_s = S_EXEC;
          end else begin
            flush_cnt_nxt_s = flush_cnt_r - FC_W'(1);
          end
        end
        S_EXEC: begin
          if (is_mem_s) begin
            to_cnt_nxt_s = TO_W'(1);
            if (mem_ack) begin
              next_state_s    = is_load_s ? S_WB : S_FLUSH;
              flush_cnt_nxt_s = FC_SLOTS;
            end else begin
              next_state_s = S_MEM_WAIT;
            end
          end else if (redirect_s) begin
            next_state_s    = S_FLUSH;
            flush_cnt_nxt_s = FC_SLOTS;
          end else begin
            next_state_s = S_EXEC;
          end
        end
        S_MEM_WAIT: begin
          if (mem_ack) begin
            next_state_s    = is_load_s ? S_WB : S_FLUSH;
            flush_cnt_nxt_s = FC_SLOTS;
          end else if (timeout_s) begin
            next_state_s    = S_FLUSH;
            flush_cnt_nxt_s = FC_SLOTS;
          end else if (to_cnt_r != TO_SAT) begin
            to_cnt_nxt_s = to_cnt_r + TO_W'(1);
          end else begin
            to_cnt_nxt_s = to_cnt_r;
          end
        end
        S_WB: begin
          next_state_s    = S_FLUSH;
          flush_cnt_nxt_s = FC_SLOTS;
        end
        default: next_state_s = S_FLUSH;
      endcase
    end
  end

  // Output decode from state and inputs; reset and its following cycle force a quiet NOP
  always_comb begin
    mem_req  = 1'b0;
    we       = 1'b0;
    mem_be   = 4'b0000;
    reg_wr   = 1'b0;
    pc_sel   = PC_OLD;
    mem_sel  = MEM_PC;
    inst_sel = INST_NOP;
    bus_err  = 1'b0;
    if (rst || post_rst_r) begin
      inst_sel = INST_NOP;
    end else begin
      case (state_r)
        S_FLUSH: begin
          pc_sel   = hold ? PC_OLD : PC_P4;
          inst_sel = hold ? INST_OLD : INST_NOP;
        end
        S_EXEC: begin
          if (hold) begin
            inst_sel = INST_OLD;
          end else if (is_mem_s) begin
            mem_req  = 1'b1;
            we       = is_store_s;
            mem_be   = byte_en(func3, addr_lo);
            mem_sel  = MEM_ALU;
            inst_sel = INST_OLD;
          end else begin
            reg_wr   = writes_rd_s;
            pc_sel   = redirect_s ? PC_ALU : PC_P4;
            inst_sel = redirect_s ? INST_NOP : INST_MEM;
          end
        end
        S_MEM_WAIT: begin
          if (!hold && timeout_s) begin
            bus_err  = 1'b1;
            inst_sel = INST_NOP;
          end else begin
            mem_req  = 1'b1;
            we       = is_store_s;
            mem_be   = byte_en(func3, addr_lo);
            mem_sel  = MEM_ALU;
            inst_sel = INST_OLD;
          end
        end
        S_WB: begin
          if (hold) begin
            inst_sel = INST_OLD;
          end else begin
            reg_wr = 1'b1;
            pc_sel = PC_P4;
          end
        end
        default: inst_sel = INST_NOP;
      endcase
    end
  end
endmodule

// File: tb/tb_ctrl_mc.sv
// Directed bench for ctrl_mc (FLUSH_SLOTS=3, RST_NOPS=2, MEM_TIMEOUT=4); one output
// bundle compared per cycle against hand-computed values.
module tb_ctrl_mc;
  localparam logic [4:0] LOAD = 5'b00000, STORE = 5'b01000, BRANCH = 5'b11000, JAL = 5'b11011;
  localparam logic [4:0] JALR = 5'b11001, OP = 5'b01100, OP_IMM = 5'b00100, BAD = 5'b11111;
  localparam logic [1:0] P4 = 2'd0, ALU = 2'd1, OLD = 2'd2;
  localparam logic [1:0] I_MEM = 2'd0, I_OLD = 2'd1, I_NOP = 2'd2;
  localparam logic       M_PC = 1'b0, M_ALU = 1'b1;

  logic       clk, rst, b, hold, mem_ack;
  logic [4:0] opcode;
  logic [2:0] func3;
  logic [1:0] addr_lo;
  logic       mem_req, we, reg_wr, mem_sel, bus_err;
  logic [3:0] mem_be;
  logic [1:0] pc_sel, inst_sel;
  int         checks = 0;
  int         errors = 0;

  ctrl_mc #(.FLUSH_SLOTS(3), .RST_NOPS(2), .MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .func3(func3), .b(b), .addr_lo(addr_lo),
    .hold(hold), .mem_ack(mem_ack), .mem_req(mem_req), .we(we), .mem_be(mem_be),
    .reg_wr(reg_wr), .pc_sel(pc_sel), .mem_sel(mem_sel), .inst_sel(inst_sel), .bus_err(bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {mem_req, we, mem_be, reg_wr, pc_sel, mem_sel, inst_sel, bus_err}
  function automatic logic [12:0] ev(input logic rq, input logic w, input logic [3:0] be,
                                     input logic rw, input logic [1:0] pc, input logic ms,
                                     input logic [1:0] is, input logic err);
    ev = {rq, w, be, rw, pc, ms, is, err};
  endfunction

  // Compare the current cycle's outputs, then advance one clock
  task automatic step(input string tag, input logic [12:0] exp);
    logic [12:0] obs;
    #1;
    obs = {mem_req, we, mem_be, reg_wr, pc_sel, mem_sel, inst_sel, bus_err};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %b expected %b", tag, obs, exp);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] opc, input logic [2:0] f3, input logic bb,
                       input logic [1:0] lo, input logic hd, input logic ack, input logic r);
    opcode = opc; func3 = f3; b = bb; addr_lo = lo; hold = hd; mem_ack = ack; rst = r;
  endtask

  logic [12:0] e_rst, e_fl, e_sh, e_lw, e_sw;

  initial begin
    e_rst = ev(1'b0, 1'b0, 4'b0000, 1'b0, OLD, M_PC, I_NOP, 1'b0);
    e_fl  = ev(1'b0, 1'b0, 4'b0000, 1'b0, P4, M_PC, I_NOP, 1'b0);
    e_sh  = ev(1'b1, 1'b1, 4'b1100, 1'b0, OLD, M_ALU, I_OLD, 1'b0);
    e_lw  = ev(1'b1, 1'b0, 4'b1111, 1'b0, OLD, M_ALU, I_OLD, 1'b0);
    e_sw  = ev(1'b1, 1'b1, 4'b1111, 1'b0, OLD, M_ALU, I_OLD, 1'b0);

    // Reset with a pending load and ack: everything quiet
    drive(LOAD, 3'b000, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) step("reset", e_rst);
    drive(LOAD, 3'b000, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
    step("post_reset", e_rst);
    step("rst_nop2", e_fl);

    drive(OP, 3'b000, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    step("exec_op", ev(1'b0, 1'b0, 4'b0000, 1'b1, P4, M_PC, I_MEM, 1'b0));
    drive(BRANCH, 3'b000, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    step("branch_nt", ev(1'b0, 1'b0, 4'b0000, 1'b0, P4, M_PC, I_MEM, 1'b0));
    drive(JAL, 3'b000, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    step("jal", ev(1'b0, 1'b0, 4'b0000, 1'b1, ALU, M_PC, I_NOP, 1'b0));
    for (int i = 0; i < 3; i++) step("jal_flush", e_fl);

    // SH at addr_lo=2, ack on third wait cycle
    drive(STORE, 3'b001, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step("sh_wait", e_sh);
    mem_ack = 1'b1;
    step("sh_ack", e_sh);
    mem_ack = 1'b0;
    for (int i = 0; i < 3; i++) step("sh_flush", e_fl);

    // LBU at addr_lo=3 acked at once, then write-back
    drive(LOAD, 3'b100, 1'b0, 2'd3, 1'b0, 1'b1, 1'b0);
    step("lbu_req", ev(1'b1, 1'b0, 4'b1000, 1'b0, OLD, M_ALU, I_OLD, 1'b0));
    mem_ack = 1'b0;
    step("lbu_wb", ev(1'b0, 1'b0, 4'b0000, 1'b1, P4, M_PC, I_NOP, 1'b0));
    for (int i = 0; i < 3; i++) step("wb_flush", e_fl);

    // LW never acked: four request cycles, then abort
    drive(LOAD, 3'b010, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step("lw_wait", e_lw);
    step("lw_timeout", ev(1'b0, 1'b0, 4'b0000, 1'b0, OLD, M_PC, I_NOP, 1'b1));
    step("to_flush", e_fl);
    step("to_flush", e_fl);
    step("to_flush", e_fl);

    // SW held for five cycles with ack ignored, then reset mid-wait
    drive(STORE, 3'b010, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0);
    step("sw_req", e_sw);
    drive(STORE, 3'b010, 1'b0, 2'd1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step("sw_hold", e_sw);
    drive(STORE, 3'b010, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0);
    step("sw_still_wait", e_sw);
    drive(STORE, 3'b010, 1'b0, 2'd1, 1'b0, 1'b1, 1'b1);
    step("sw_rst", e_rst);
    drive(STORE, 3'b010, 1'b0, 2'd1, 1'b0, 1'b1, 1'b0);
    step("late_ack_post", e_rst);
    step("late_ack_flush", e_fl);

    drive(BAD, 3'b000, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    step("unknown_nop", ev(1'b0, 1'b0, 4'b0000, 1'b0, P4, M_PC, I_MEM, 1'b0));
    drive(JALR, 3'b000, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
    step("jalr_hold", ev(1'b0, 1'b0, 4'b0000, 1'b0, OLD, M_PC, I_OLD, 1'b0));
    hold = 1'b0;
    step("jalr", ev(1'b0, 1'b0, 4'b0000, 1'b1, ALU, M_PC, I_NOP, 1'b0));
    drive(OP_IMM, 3'b000, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    step("jalr_flush", e_fl);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
